// File: rtl/nor_bus_pkg.sv
// Shared types and widths for the NOR flash bus sequencer.
package nor_bus_pkg;

  localparam int unsigned NOR_ADDR_W = 26;
  localparam int unsigned NOR_DATA_W = 16;
  localparam int unsigned NOR_TCNT_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StWaitRy,
    StSetup,
    StAccess,
    StHold,
    StAck
  } nor_state_e;

  // Counter load value for a timed state; 0 behaves as 1, anything above 255 saturates.
  function automatic logic [NOR_TCNT_W-1:0] tcnt_load(input int unsigned t);
    int unsigned c;
    c = (t == 0) ? 1 : ((t > 255) ? 255 : t);
    return NOR_TCNT_W'(c - 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync_2ff #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/nor_bus_sequencer.sv
// Single-word Wishbone-to-NOR flash bus cycle sequencer with RY/BY# gating.
// Optional WAIT_RY timeout is built when NOR_RY_TIMEOUT_EN is defined.
module nor_bus_sequencer
  import nor_bus_pkg::*;
#(
  parameter int unsigned T_SETUP    = 2,
  parameter int unsigned T_ACCESS   = 6,
  parameter int unsigned T_HOLD     = 2,
  parameter int unsigned RY_TIMEOUT = 65535
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [NOR_ADDR_W-1:0] wb_adr_i,
  input  logic [NOR_DATA_W-1:0] wb_dat_i,
  output logic [NOR_DATA_W-1:0] wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  input  logic                  nor_ry_i,
  input  logic [NOR_DATA_W-1:0] nor_data_i,
  output logic [NOR_ADDR_W-1:0] nor_addr_o,
  output logic [NOR_DATA_W-1:0] nor_data_o,
  output logic                  nor_data_oe,
  output logic                  nor_ce_o,
  output logic                  nor_oe_o,
  output logic                  nor_we_o,
  output logic                  busy_o
);

`ifdef NOR_RY_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  localparam logic [NOR_TCNT_W-1:0] SetupLd  = tcnt_load(T_SETUP);
  localparam logic [NOR_TCNT_W-1:0] AccessLd = tcnt_load(T_ACCESS);
  localparam logic [NOR_TCNT_W-1:0] HoldLd   = tcnt_load(T_HOLD);
  localparam logic [NOR_TCNT_W-1:0] TcntOne  = 1;

  localparam int unsigned RyToClamp = (RY_TIMEOUT == 0) ? 1 :
                                      ((RY_TIMEOUT > 65535) ? 65535 : RY_TIMEOUT);
  localparam logic [15:0] TimeoutLd = 16'(RyToClamp - 1);

  logic ry_sync;

  sync_2ff #(
    .ResetVal(1'b0)
  ) u_ry_sync (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .d_i    (nor_ry_i),
    .q_o    (ry_sync)
  );

  nor_state_e                state_q, state_d;
  logic [NOR_TCNT_W-1:0]     cnt_q, cnt_d;
  logic [15:0]               to_q, to_d;
  logic                      abort_q, abort_d;
  logic                      we_q, we_d;
  logic [NOR_ADDR_W-1:0]     addr_q, addr_d;
  logic [NOR_DATA_W-1:0]     data_q, data_d;
  logic [NOR_DATA_W-1:0]     rdat_q, rdat_d;
  logic                      timeout_hit;

  logic ce_n_q, ce_n_d;
  logic oe_n_q, oe_n_d;
  logic we_n_q, we_n_d;
  logic doe_q, doe_d;
  logic busy_q, busy_d;
  logic ack_q, ack_d;
  logic err_q, err_d;
  logic active;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      to_q    <= '0;
      abort_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdat_q  <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      doe_q   <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      abort_q <= abort_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdat_q  <= rdat_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      doe_q   <= doe_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    to_d        = to_q;
    abort_d     = abort_q;
    we_d        = we_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rdat_d      = rdat_q;
    timeout_hit = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wb_cyc_i && wb_stb_i) begin
          we_d    = wb_we_i;
          addr_d  = wb_adr_i;
          data_d  = wb_dat_i;
          abort_d = 1'b0;
          to_d    = '0;
          if (ry_sync) begin
            state_d = StSetup;
            cnt_d   = SetupLd;
          end else begin
            state_d = StWaitRy;
          end
        end
      end
      StWaitRy: begin
        if (!wb_cyc_i) begin
          state_d = StIdle;
        end else if (ry_sync) begin
          state_d = StSetup;
          cnt_d   = SetupLd;
        end else if (TimeoutEn && (to_q == TimeoutLd)) begin
          // Error ends the request through ACK without ever lowering CE#.
          state_d     = StAck;
          timeout_hit = 1'b1;
        end else if (TimeoutEn) begin
          to_d = to_q + 16'd1;
        end
      end
      StSetup: begin
        if (!wb_cyc_i) begin
          state_d = StHold;
          cnt_d   = HoldLd;
          abort_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = StAccess;
          cnt_d   = AccessLd;
        end else begin
          cnt_d = cnt_q - TcntOne;
        end
      end
      StAccess: begin
        if (!wb_cyc_i) begin
          state_d = StHold;
          cnt_d   = HoldLd;
          abort_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = StHold;
          cnt_d   = HoldLd;
          if (!we_q) rdat_d = nor_data_i;
        end else begin
          cnt_d = cnt_q - TcntOne;
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d = abort_q ? StIdle : StAck;
        end else begin
          cnt_d = cnt_q - TcntOne;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Pin strobes are decoded from the next state and registered, so no wb_* input reaches a pin.
  always_comb begin
    active = (state_d == StSetup) || (state_d == StAccess) || (state_d == StHold);
    ce_n_d = ~active;
    oe_n_d = ~((state_d == StAccess) && !we_d);
    we_n_d = ~((state_d == StAccess) && we_d);
    doe_d  = active && we_d;
    busy_d = (state_d != StIdle);
    ack_d  = (state_d == StAck) && !timeout_hit;
    err_d  = timeout_hit;
  end

  assign wb_dat_o    = rdat_q;
  assign wb_ack_o    = ack_q;
  assign wb_err_o    = err_q;
  assign nor_addr_o  = addr_q;
  assign nor_data_o  = data_q;
  assign nor_data_oe = doe_q;
  assign nor_ce_o    = ce_n_q;
  assign nor_oe_o    = oe_n_q;
  assign nor_we_o    = we_n_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_nor_bus_sequencer.sv
// Self-checking bench for nor_bus_sequencer: directed and randomized transfers against a
// cycle-window model of the pin sequence.
module tb_nor_bus_sequencer;

  localparam int TS = 2;
  localparam int TA = 6;
  localparam int TH = 2;
  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_cyc, wb_stb, wb_we;
  logic [25:0] wb_adr;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic        wb_ack, wb_err;
  logic        nor_ry;
  logic [15:0] nor_data_i;
  logic [25:0] nor_addr;
  logic [15:0] nor_data_o;
  logic        nor_data_oe;
  logic        nor_ce, nor_oe, nor_we;
  logic        busy;
  logic [15:0] flash_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Flash model: drives the stored word only while OE# is low.
  assign nor_data_i = nor_oe ? 16'hDEAD : flash_val;

  nor_bus_sequencer #(
    .T_SETUP   (TS),
    .T_ACCESS  (TA),
    .T_HOLD    (TH),
    .RY_TIMEOUT(TO)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .wb_cyc_i   (wb_cyc),
    .wb_stb_i   (wb_stb),
    .wb_we_i    (wb_we),
    .wb_adr_i   (wb_adr),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack),
    .wb_err_o   (wb_err),
    .nor_ry_i   (nor_ry),
    .nor_data_i (nor_data_i),
    .nor_addr_o (nor_addr),
    .nor_data_o (nor_data_o),
    .nor_data_oe(nor_data_oe),
    .nor_ce_o   (nor_ce),
    .nor_oe_o   (nor_oe),
    .nor_we_o   (nor_we),
    .busy_o     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One transfer, entered and left just after a rising edge. ry_rel > 0: RY is low and
  // rises ry_rel cycles after the request. abort_ac > 0: cyc drops in that ACCESS cycle.
  task automatic xfer(input bit w, input logic [25:0] a, input logic [15:0] d,
                      input int ry_rel, input int abort_ac, input bit b2b);
    int s0, last_acc, end_j, n_ce, n_oe, n_we;
    bit ce_exp, acc;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = w; wb_adr = a; wb_dat_i = d;
    flash_val = 16'($urandom);
    // First SETUP cycle: 2 synchronizer flops plus one registered state step after release.
    s0 = (ry_rel > 0) ? ry_rel + 3 : 1;
    last_acc = (abort_ac > 0) ? s0 + TS + abort_ac - 1 : s0 + TS + TA - 1;
    end_j = last_acc + TH + 1;
    n_ce = 0; n_oe = 0; n_we = 0;
    @(negedge clk);
    chk("idle_ce", 32'(nor_ce), 32'(1));
    chk("idle_busy", 32'(busy), 32'(0));
    for (int j = 1; j <= end_j; j++) begin
      @(posedge clk); #1;
      if (ry_rel > 0 && j == ry_rel) nor_ry = 1'b1;
      if (abort_ac > 0 && j == last_acc) begin wb_cyc = 1'b0; wb_stb = 1'b0; end
      @(negedge clk);
      ce_exp = (j >= s0) && (j <= last_acc + TH);
      acc = (j >= s0 + TS) && (j <= last_acc);
      if (!nor_ce) n_ce++;
      if (!nor_oe) n_oe++;
      if (!nor_we) n_we++;
      chk("ce", 32'(nor_ce), 32'(!ce_exp));
      chk("oe", 32'(nor_oe), 32'(!(acc && !w)));
      chk("we", 32'(nor_we), 32'(!(acc && w)));
      chk("data_oe", 32'(nor_data_oe), 32'(ce_exp && w));
      chk("busy", 32'(busy), 32'(!(j == end_j && abort_ac > 0)));
      chk("ack", 32'(wb_ack), 32'(j == end_j && abort_ac == 0));
      chk("err", 32'(wb_err), 32'(0));
      chk("addr", 32'(nor_addr), 32'(a));
      if (ce_exp && w) chk("wdata", 32'(nor_data_o), 32'(d));
      if (j == end_j && abort_ac == 0 && !w) chk("rdata", 32'(wb_dat_o), 32'(flash_val));
    end
    chk("ce_len", 32'(n_ce), 32'(last_acc + TH - s0 + 1));
    chk("oe_len", 32'(n_oe), 32'(w ? 0 : last_acc - s0 - TS + 1));
    chk("we_len", 32'(n_we), 32'(w ? last_acc - s0 - TS + 1 : 0));
    @(posedge clk); #1;
    if (!b2b) begin
      wb_cyc = 1'b0; wb_stb = 1'b0;
      @(negedge clk);
      chk("post_ack", 32'(wb_ack), 32'(0));
      chk("post_busy", 32'(busy), 32'(0));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit w, b2b;
    reset = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_adr = '0; wb_dat_i = '0; nor_ry = 1'b1; flash_val = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ce", 32'(nor_ce), 32'(1));
    chk("rst_oe", 32'(nor_oe), 32'(1));
    chk("rst_we", 32'(nor_we), 32'(1));
    chk("rst_doe", 32'(nor_data_oe), 32'(0));
    chk("rst_addr", 32'(nor_addr), 32'(0));
    chk("rst_wdata", 32'(nor_data_o), 32'(0));
    chk("rst_rdata", 32'(wb_dat_o), 32'(0));
    chk("rst_ack", 32'(wb_ack), 32'(0));
    chk("rst_err", 32'(wb_err), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Directed read and write from the plan.
    xfer(1'b0, 26'h155_5555, 16'h0000, 0, 0, 1'b0);
    xfer(1'b1, 26'h000_02AA, 16'h00F0, 0, 0, 1'b0);

    // RY busy at request, released 20 cycles later.
    nor_ry = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    xfer(1'b0, 26'h0AB_CDEF, 16'h0000, 20, 0, 1'b0);

    // cyc dropped in the 3rd ACCESS cycle, read and write.
    xfer(1'b0, 26'h012_3456, 16'h0000, 0, 3, 1'b0);
    xfer(1'b1, 26'h3FF_FFFF, 16'hBEEF, 0, 3, 1'b0);

    // Randomized traffic, including back-to-back requests.
    for (int i = 0; i < 10; i++) begin
      w = 1'($urandom_range(0, 1));
      b2b = (i != 9) && ($urandom_range(0, 1) == 1);
      xfer(w, 26'($urandom), 16'($urandom), 0, 0, b2b);
    end

    // Reset in the middle of a write.
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 26'h000_1234; wb_dat_i = 16'h5A5A;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_ce", 32'(nor_ce), 32'(1));
    chk("mrst_we", 32'(nor_we), 32'(1));
    chk("mrst_doe", 32'(nor_data_oe), 32'(0));
    chk("mrst_busy", 32'(busy), 32'(0));
    chk("mrst_ack", 32'(wb_ack), 32'(0));
    @(posedge clk); #1;
    reset = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    xfer(1'b0, 26'h000_0001, 16'h0000, 0, 0, 1'b0);

`ifdef NOR_RY_TIMEOUT_EN
    begin
      int n_err, n_ce;
      n_err = 0; n_ce = 0;
      nor_ry = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 26'h000_0777;
      @(posedge clk);
      // WAIT_RY is entered at this edge; the error pulse lands TO cycles later.
      for (int j = 1; j <= TO + 3; j++) begin
        @(negedge clk);
        chk("to_err", 32'(wb_err), 32'(j == TO + 1));
        chk("to_ack", 32'(wb_ack), 32'(0));
        if (wb_err) n_err++;
        if (!nor_ce) n_ce++;
        @(posedge clk); #1;
        if (j == TO + 1) begin wb_cyc = 1'b0; wb_stb = 1'b0; end
      end
      chk("to_err_cnt", 32'(n_err), 32'(1));
      chk("to_ce_low", 32'(n_ce), 32'(0));
      nor_ry = 1'b1;
      repeat (3) @(posedge clk);
      #1;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
